// File: rtl/flb_sdm_pkg.sv
// ============================================================================
// Module   : flb_sdm_pkg
// Brief    : Shared types and constants for the FLB sigma-delta link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flb_sdm_pkg;

    typedef logic [1:0] sdm_sym_t;

    localparam logic [2:0] THRM_0 = 3'b000;
    localparam logic [2:0] THRM_1 = 3'b001;
    localparam logic [2:0] THRM_2 = 3'b011;
    localparam logic [2:0] THRM_3 = 3'b111;

    localparam int OS_OFFSET = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } demod_state_t;

    function automatic logic [7:0] clamp_u8(input logic signed [10:0] v);
        if (v < 0)
            return 8'h00;
        else if (v > 11'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/flb_sdm_sym_dec.sv
// ============================================================================
// Module   : flb_sdm_sym_dec
// Brief    : Binary / thermometer symbol decode with illegal-code indication.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flb_sdm_sym_dec
    import flb_sdm_pkg::*;
(
    input  logic       i_thrm_en,
    input  logic [1:0] i_os_bin,
    input  logic [2:0] i_os_thrm,
    output logic [1:0] o_sym,
    output logic       o_thrm_ill
);

    logic [1:0] w_pop;
    logic       w_legal;

    // Legal codes map to their popcount, so illegal codes fall back to it too.
    assign w_pop = {1'b0, i_os_thrm[0]} + {1'b0, i_os_thrm[1]} + {1'b0, i_os_thrm[2]};

    always_comb begin
        w_legal = 1'b0;
        case (i_os_thrm)
            THRM_0, THRM_1, THRM_2, THRM_3: w_legal = 1'b1;
            default:                        w_legal = 1'b0;
        endcase
    end

    assign o_sym      = i_thrm_en ? w_pop : i_os_bin;
    assign o_thrm_ill = i_thrm_en && !w_legal;

endmodule

`default_nettype wire

// File: rtl/flb_sdm_demod.sv
// ============================================================================
// Module   : flb_sdm_demod
// Brief    : Decimating sinc1/sinc2 demodulator for the FLB SDM offset stream.
//            Sinc2 path built only when FLB_SDM_DEMOD_SINC2_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flb_sdm_demod
    import flb_sdm_pkg::*;
#(
    parameter int DECIM_LOG2 = 8
) (
    input  logic       nsh_clk,
    input  logic       nsh_rst_n,
    input  logic       csr_flb_sdm_en,
    input  logic       csr_flb_sdm_order,
    input  logic       csr_flb_sdm_thrm_en,
    input  logic [1:0] os_bin,
    input  logic [2:0] os_thrm,
    output logic [7:0] s_os_est,
    output logic       s_os_vld,
    output logic       thrm_err
);

    localparam int c_D   = DECIM_LOG2;
    localparam int c_AW1 = c_D + 2;
    localparam int c_SH1 = c_D - 8;
    localparam logic [c_D-1:0] c_CNT_LAST = '1;

    demod_state_t          r_state, w_state_nxt;
    logic                  r_thrm_q;
    logic [c_D-1:0]        r_cnt;
    logic [c_AW1-1:0]      r_acc1, w_s1;
    logic [9:0]            w_q1;
    logic signed [10:0]    w_e1;
    logic [7:0]            r_est_pend, w_est;
    logic                  r_pend;
    logic [1:0]            w_sym;
    logic                  w_ill, w_sinc2, w_mode_chg, w_sample, w_win_end, w_dump;

    flb_sdm_sym_dec u_sym_dec (
        .i_thrm_en  (csr_flb_sdm_thrm_en),
        .i_os_bin   (os_bin),
        .i_os_thrm  (os_thrm),
        .o_sym      (w_sym),
        .o_thrm_ill (w_ill)
    );

`ifdef FLB_SDM_DEMOD_SINC2_EN
    localparam int c_AW2 = 2 * c_D + 2;
    localparam int c_SH2 = 2 * c_D - 8;

    logic                  r_order_q;
    logic [c_AW2-1:0]      r_i1, r_i2, r_z1, r_z2;
    logic [c_AW2-1:0]      w_i1_nxt, w_i2_nxt, w_c1, w_c2;
    logic [9:0]            w_q2;
    logic signed [10:0]    w_e2;

    assign w_sinc2    = csr_flb_sdm_order;
    assign w_mode_chg = (csr_flb_sdm_thrm_en != r_thrm_q) || (csr_flb_sdm_order != r_order_q);

    // Integrators run every sample; modular wrap cancels in the comb differences.
    assign w_i1_nxt = r_i1 + {{(c_AW2-2){1'b0}}, w_sym};
    assign w_i2_nxt = r_i2 + w_i1_nxt;
    assign w_c1     = w_i2_nxt - r_z1;
    assign w_c2     = w_c1 - r_z2;
    assign w_q2     = 10'(w_c2 >> c_SH2);
    assign w_e2     = $signed({1'b0, w_q2}) - $signed(11'(OS_OFFSET));
    assign w_est    = w_sinc2 ? clamp_u8(w_e2) : clamp_u8(w_e1);

    always_ff @(posedge nsh_clk) begin
        if (!nsh_rst_n) begin
            r_order_q <= 1'b0;
            r_i1      <= '0;
            r_i2      <= '0;
            r_z1      <= '0;
            r_z2      <= '0;
        end else begin
            r_order_q <= csr_flb_sdm_order;
            if (!csr_flb_sdm_en || w_mode_chg) begin
                r_i1 <= '0;
                r_i2 <= '0;
                r_z1 <= '0;
                r_z2 <= '0;
            end else begin
                r_i1 <= w_i1_nxt;
                r_i2 <= w_i2_nxt;
                if (w_win_end) begin
                    r_z1 <= w_i2_nxt;
                    r_z2 <= w_c1;
                end
            end
        end
    end
`else
    logic w_unused_order;

    assign w_unused_order = csr_flb_sdm_order;
    assign w_sinc2        = 1'b0;
    assign w_mode_chg     = (csr_flb_sdm_thrm_en != r_thrm_q);
    assign w_est          = clamp_u8(w_e1);
`endif

    assign w_sample  = csr_flb_sdm_en && !w_mode_chg;
    assign w_win_end = w_sample && (r_cnt == c_CNT_LAST);
    assign w_dump    = w_win_end && (r_state == RUN);
    assign w_s1      = r_acc1 + {{(c_AW1-2){1'b0}}, w_sym};
    assign w_q1      = 10'(w_s1 >> c_SH1);
    assign w_e1      = $signed({1'b0, w_q1}) - $signed(11'(OS_OFFSET));

    always_ff @(posedge nsh_clk) begin
        if (!nsh_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A restart lands in WARM for sinc2 so the first comb output is dropped.
    always_comb begin
        w_state_nxt = r_state;
        if (!csr_flb_sdm_en)
            w_state_nxt = IDLE;
        else if ((r_state == IDLE) || w_mode_chg)
            w_state_nxt = w_sinc2 ? WARM : RUN;
        else if ((r_state == WARM) && w_win_end)
            w_state_nxt = RUN;
    end

    always_ff @(posedge nsh_clk) begin
        if (!nsh_rst_n) begin
            r_thrm_q   <= 1'b0;
            r_cnt      <= '0;
            r_acc1     <= '0;
            r_pend     <= 1'b0;
            r_est_pend <= 8'h00;
            s_os_est   <= 8'h00;
            s_os_vld   <= 1'b0;
            thrm_err   <= 1'b0;
        end else begin
            r_thrm_q <= csr_flb_sdm_thrm_en;
            if (!csr_flb_sdm_en || w_mode_chg) begin
                r_cnt  <= '0;
                r_acc1 <= '0;
                r_pend <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_acc1 <= w_win_end ? '0 : w_s1;
                r_pend <= w_dump;
                if (w_dump)
                    r_est_pend <= w_est;
            end

            if (!csr_flb_sdm_en) begin
                s_os_est <= 8'h00;
                s_os_vld <= 1'b0;
                thrm_err <= 1'b0;
            end else begin
                s_os_vld <= r_pend && !w_mode_chg;
                if (r_pend && !w_mode_chg)
                    s_os_est <= r_est_pend;
                if (w_sample && w_ill)
                    thrm_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flb_sdm_demod.sv
// ============================================================================
// Module   : tb_flb_sdm_demod
// Brief    : Directed self-checking bench for flb_sdm_demod (DECIM_LOG2 = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flb_sdm_demod;

    localparam int c_N = 256;

    logic       nsh_clk = 1'b0;
    logic       nsh_rst_n;
    logic       csr_flb_sdm_en;
    logic       csr_flb_sdm_order;
    logic       csr_flb_sdm_thrm_en;
    logic [1:0] os_bin;
    logic [2:0] os_thrm;
    logic [7:0] s_os_est;
    logic       s_os_vld;
    logic       thrm_err;

    int         n_vec = 0;
    int         n_err = 0;
    int         smp   = 0;
    int         pat   = 0;
    logic [1:0] pconst = 2'd0;
    int         inj_at = 0;
    int         sdm_acc = 0;
    int         sdm_s   = 64;

    always #5 nsh_clk = ~nsh_clk;

    flb_sdm_demod #(.DECIM_LOG2(8)) dut (
        .nsh_clk             (nsh_clk),
        .nsh_rst_n           (nsh_rst_n),
        .csr_flb_sdm_en      (csr_flb_sdm_en),
        .csr_flb_sdm_order   (csr_flb_sdm_order),
        .csr_flb_sdm_thrm_en (csr_flb_sdm_thrm_en),
        .os_bin              (os_bin),
        .os_thrm             (os_thrm),
        .s_os_est            (s_os_est),
        .s_os_vld            (s_os_vld),
        .thrm_err            (thrm_err)
    );

    function automatic logic [2:0] enc(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s smp=%0d: observed %h expected %h", tag, smp, obs, want);
        end
    endtask

    task automatic clk1();
        @(posedge nsh_clk);
        #1;
    endtask

    // Drive the next sample's symbol from the selected source, then clock it in.
    task automatic step();
        logic [1:0] s;
        case (pat)
            0: s = pconst;
            1: s = (((smp + 1) % 2) == 1) ? 2'd1 : 2'd2;
            default: begin
                sdm_acc += sdm_s;
                if (sdm_acc >= 256) begin
                    sdm_acc -= 256;
                    s = 2'd2;
                end else begin
                    s = 2'd1;
                end
            end
        endcase
        if (csr_flb_sdm_thrm_en) begin
            os_thrm = ((smp + 1) == inj_at) ? 3'b010 : enc(s);
            os_bin  = ~s;
        end else begin
            os_bin  = s;
            os_thrm = 3'b101;
        end
        clk1();
        smp++;
    endtask

    task automatic start(input logic thrm, input logic order, input int p, input logic [1:0] c);
        csr_flb_sdm_en      = 1'b0;
        csr_flb_sdm_thrm_en = thrm;
        csr_flb_sdm_order   = order;
        pat = p; pconst = c; sdm_acc = 0; inj_at = 0;
        clk1();
        clk1();
        chk("dis_est", s_os_est, 8'h00);
        chk("dis_vld", {7'd0, s_os_vld}, 8'h00);
        chk("dis_err", {7'd0, thrm_err}, 8'h00);
        csr_flb_sdm_en = 1'b1;
        smp = 0;
    endtask

    task automatic restart(input logic thrm, input logic order, input int p, input logic [1:0] c,
                           input logic [7:0] held);
        csr_flb_sdm_thrm_en = thrm;
        csr_flb_sdm_order   = order;
        pat = p; pconst = c; sdm_acc = 0;
        clk1();
        chk("rst_vld", {7'd0, s_os_vld}, 8'h00);
        chk("rst_est", s_os_est, held);
        smp = 0;
    endtask

    task automatic run_check(input string tn, input int ncyc, input int first_vld,
                             input logic [7:0] want, input int tol,
                             input logic [7:0] start_est, input int err_at);
        logic [7:0] hold;
        logic       exp_vld;
        hold = start_est;
        for (int k = 0; k < ncyc; k++) begin
            step();
            exp_vld = (smp >= first_vld) && (((smp - first_vld) % c_N) == 0);
            chk({tn, "_vld"}, {7'd0, s_os_vld}, {7'd0, exp_vld});
            if (exp_vld)
                hold = want;
            if (tol == 0) begin
                chk({tn, "_est"}, s_os_est, hold);
            end else if (exp_vld) begin
                n_vec++;
                assert ((int'(s_os_est) >= int'(want) - tol) && (int'(s_os_est) <= int'(want) + tol))
                else begin
                    n_err++;
                    $error("FAIL %s_est smp=%0d: observed %h expected %h+/-%0d",
                           tn, smp, s_os_est, want, tol);
                end
            end
            chk({tn, "_err"}, {7'd0, thrm_err}, {7'd0, (err_at > 0) && (smp >= err_at)});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nsh_rst_n = 1'b0; csr_flb_sdm_en = 1'b1; csr_flb_sdm_order = 1'b0;
        csr_flb_sdm_thrm_en = 1'b1; os_bin = 2'd3; os_thrm = 3'b010;
        #1;
        repeat (3) clk1();
        chk("reset_est", s_os_est, 8'h00);
        chk("reset_vld", {7'd0, s_os_vld}, 8'h00);
        chk("reset_err", {7'd0, thrm_err}, 8'h00);
        nsh_rst_n = 1'b1;

        // Sinc1 binary: constant 1 gives zero offset every window.
        start(1'b0, 1'b0, 0, 2'd1);
        run_check("s1c1", 520, 257, 8'h00, 0, 8'h00, 0);

        // Alternating 1,2 -> 0x80; mode changes restart and hold the estimate.
        start(1'b0, 1'b0, 1, 2'd0);
        run_check("s1alt", 260, 257, 8'h80, 0, 8'h00, 0);
        restart(1'b1, 1'b0, 0, 2'd3, 8'h80);
        run_check("s1c3", 260, 257, 8'hFF, 0, 8'h80, 0);
        restart(1'b0, 1'b0, 0, 2'd0, 8'hFF);
        run_check("s1c0", 260, 257, 8'h00, 0, 8'hFF, 0);

        // Thermometer stream with one illegal code at sample 50.
        start(1'b1, 1'b0, 0, 2'd1);
        inj_at = 50;
        run_check("thrm", 260, 257, 8'h00, 0, 8'h00, 50);

        // Disable mid-window, then re-enable: window restarts from scratch.
        start(1'b0, 1'b0, 1, 2'd0);
        run_check("pre", 356, 257, 8'h80, 0, 8'h00, 0);
        start(1'b0, 1'b0, 1, 2'd0);
        run_check("post", 260, 257, 8'h80, 0, 8'h00, 0);

        // Loopback from a first-order SDM model carrying 0x40.
        start(1'b0, 1'b0, 2, 2'd0);
        run_check("lb1b", 520, 257, 8'h40, 1, 8'h00, 0);
        start(1'b1, 1'b0, 2, 2'd0);
        run_check("lb1t", 520, 257, 8'h40, 1, 8'h00, 0);

`ifdef FLB_SDM_DEMOD_SINC2_EN
        start(1'b0, 1'b1, 1, 2'd0);
        run_check("s2alt", 780, 513, 8'h80, 0, 8'h00, 0);
        start(1'b0, 1'b1, 2, 2'd0);
        run_check("lb2b", 780, 513, 8'h40, 1, 8'h00, 0);
        start(1'b1, 1'b1, 2, 2'd0);
        run_check("lb2t", 780, 513, 8'h40, 1, 8'h00, 0);
        start(1'b0, 1'b0, 1, 2'd0);
        run_check("s1pre", 300, 257, 8'h80, 0, 8'h00, 0);
        restart(1'b0, 1'b1, 1, 2'd0, 8'h80);
        run_check("s2chg", 600, 513, 8'h80, 0, 8'h80, 0);
`else
        // Without sinc2 the order bit is ignored, including changes mid-window.
        start(1'b0, 1'b1, 1, 2'd0);
        run_check("ord1", 520, 257, 8'h80, 0, 8'h00, 0);
        csr_flb_sdm_order = 1'b0;
        run_check("ord0", 260, 257, 8'h80, 0, 8'h80, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flb_sdm_demod.md
# flb_sdm_demod

Decimating demodulator for the FLB sigma-delta offset stream. It consumes the 2-bit binary or 3-bit thermometer symbol stream produced by the FLB SDM. It reconstructs the 8-bit offset value `s_os` through a sinc1 or sinc2 decimation filter. It sits on the receive side of the SDM link and also serves as the loopback checker in self-test.

## Interface
- `DECIM_LOG2`, default 8: log2 of decimation window N; legal range 8..10.
- `nsh_clk` in 1: clock; all state on rising edge.
- `nsh_rst_n` in 1: reset, synchronous, active-low.
- `csr_flb_sdm_en` in 1: enable; low acts as a synchronous clear of all filter state.
- `csr_flb_sdm_order` in 1: 0 selects sinc1, 1 selects sinc2.
- `csr_flb_sdm_thrm_en` in 1: 1 decodes `os_thrm`, 0 decodes `os_bin`.
- `os_bin` in 2: binary symbol, value 0..3.
- `os_thrm` in 3: thermometer symbol.
- `s_os_est` out 8: reconstructed offset; holds between updates.
- `s_os_vld` out 1: one-cycle pulse when `s_os_est` updates.
- `thrm_err` out 1: sticky flag for an illegal thermometer code.

## Operation
- **Symbol decode:**
  - Binary mode uses `os_bin` directly.
  - Thermometer mode maps 000→0, 001→1, 011→2, 111→3.
  - Any other code decodes to its popcount and sets `thrm_err`.
  - `thrm_err` clears only on reset or `csr_flb_sdm_en`=0.
- **Sampling:** one symbol per cycle while enabled. Window counter D bits wide, wraps every N=2^DECIM_LOG2 samples.
- **Sinc1:**
  - Accumulator is D+2 bits wide and is dumped at the end of each window.
  - Sum S = N + s·2^(D-8) nominally.
  - Estimate = (S >> (D-8)) − 256.
- **Sinc2:**
  - Two integrators and two combs at the decimated rate.
  - 2D+2-bit modular arithmetic; wrap is intentional and harmless.
  - Output C = N² + s·N·2^(D-8).
  - Estimate = (C >> (2D-8)) − 256.
  - The first decimated output after a (re)start is discarded as warm-up.
- **Clamp:** the estimate is computed signed (≥11 bits). Below 0 → 0; above 255 → 255.
- **Mode change:**
  - `csr_flb_sdm_order` and `csr_flb_sdm_thrm_en` are registered each cycle.
  - Any change while enabled restarts the window, clears accumulators and warm-up, and discards the current window.
  - `s_os_est` holds its last value.
- **Disable or reset mid-window:**
  - All accumulators and counters clear.
  - `s_os_est`=0, `s_os_vld`=0.
  - Partial window discarded.
- **States:** IDLE (disabled) → WARM (sinc2 first window only) → RUN. A mode change returns to WARM for sinc2, or to RUN for sinc1.

## Timing
- **Reset values:** `s_os_est`=0x00, `s_os_vld`=0, `thrm_err`=0.
- **Sample numbering:** sample 1 is taken on the first rising edge with `nsh_rst_n`=1 and `csr_flb_sdm_en`=1.
- **Sinc1:** window k ends at sample k·N. `s_os_est` and `s_os_vld` update on the next edge, a one-cycle latency.
- **Sinc2:** first `s_os_vld` is on the edge after sample 2N, then every N cycles.
- **Validity:** `s_os_vld` is never asserted in IDLE, in WARM, or in the cycle of a mode-change restart.
- **Error flag:** `thrm_err` rises on the edge that samples the illegal code.

## Configuration
- Macro: `FLB_SDM_DEMOD_SINC2_EN`.
- Defined: sinc2 path compiled in; `csr_flb_sdm_order` selects the filter.
- Undefined: sinc2 logic and the WARM state are removed. `csr_flb_sdm_order` is ignored, so its changes do not restart the window, and sinc1 is always used.

## Structure
- Shared package `flb_sdm_pkg` holds:
  - the thermometer code constants `THRM_0`..`THRM_3`;
  - the `sdm_sym_t` typedef (2-bit);
  - the state enum `demod_state_t` (IDLE/WARM/RUN);
  - the `OS_OFFSET`=256 constant.
- Sub-module `flb_sdm_sym_dec`: combinational thermometer/binary decode plus an illegal-code indication. All filter and control logic stays in the top.

## Test plan
1. Sinc1, binary mode, `os_bin`=1 constant, D=8 → `s_os_vld` on the edge after sample 256 with `s_os_est`=0x00, repeating every 256 cycles.
2. Sinc1, `os_bin` alternating 1,2 → `s_os_est`=0x80. Constant 3 → clamps to 0xFF.
3. Thermometer mode, `os_thrm`=3'b010 once inside a 001 stream → `thrm_err`=1 and stays high. Estimate equals that of a clean 001 stream, 0x00.
4. Sinc2, `os_bin` alternating 1,2 → first `s_os_vld` after sample 512 with `s_os_est`=0x80; none at sample 256.
5. Drop `csr_flb_sdm_en` at sample 100, re-enable → outputs 0 while disabled; next `s_os_vld` exactly 256 samples after re-enable.
6. Loopback from the FLB SDM with `s_os`=0x40, both orders and both formats → `s_os_est` within 0x40±1 on every valid window.
